perf_section_trigger: RTL
=========================

Name: perf_section_trigger

Overview:
- Avalon-MM write master that sits directly upstream of the performance counter control slave.
- Converts single-cycle hardware section start/stop pulses and a global-reset request into the slave's register writes: STOP (offset 0), GO (offset 1), and global reset (offset 0 with writedata[0]=1).
- Section profiling can then be driven from RTL events instead of CPU stores.
- Pending-event bitmap, fixed-priority arbiter, two-state write FSM, saturating drop counter.

Parameters:
- NUM_SECTIONS, 4, number of counter sections served (1..4); section s uses word addresses 4*s (STOP) and 4*s+1 (GO).
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sec_start  in  NUM_SECTIONS  one-cycle pulse per section: request a GO write.
- sec_stop  in  NUM_SECTIONS  one-cycle pulse per section: request a STOP write.
- global_clear  in  1  one-cycle pulse: request a global reset write (address 0, data 1).
- avm_address  out  4  word address to the counter slave.
- avm_write  out  1  write request.
- avm_begintransfer  out  1  high only on the first cycle of each write.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  any pending bit set, or FSM in WRITE.
- drop_count  out  DROP_W  saturating count of lost events.

Behaviour:
- Reset (async, active-high):
  - All pending bits = 0; FSM = IDLE.
  - avm_write, avm_begintransfer, busy = 0; avm_address = 0; avm_writedata = 0; drop_count = 0.
- Pending bits: pend_clr, pend_stop[s], pend_start[s].
  - Each bit is set at the clock edge where its input pulse is high.
  - A bit is cleared at the edge where its write completes.
  - If set and clear coincide on the same bit, set wins: the bit stays 1 and nothing is dropped.
  - A pulse arriving while its bit is already 1 and not being cleared is dropped: drop_count += 1 per dropped bit that cycle, saturating at all-ones.
  - Several different pulses in one cycle are all captured.
- Arbitration (fixed priority, evaluated in IDLE only): pend_clr > pend_stop[0..N-1] (lowest index first) > pend_start[0..N-1] (lowest index first).
- Encoding:
  - clr: address 0, data 1.
  - stop[s]: address 4*s, data 0.
  - start[s]: address 4*s+1, data 0.
  - Upper 31 data bits are always 0.
- FSM:
  - IDLE: if any pending bit is set, register the winner's address/data and a one-hot "granted" tag, then go to WRITE. avm_write = 1 and avm_begintransfer = 1 from the next cycle.
  - WRITE: avm_write = 1; avm_begintransfer = 1 only on the first WRITE cycle.
    - Hold address/data stable while avm_waitrequest = 1.
    - When avm_waitrequest = 0: clear the granted bit and return to IDLE.
- Latency: pulse at edge E0 sets the pending bit; write is visible after E1; it completes at E2 with no waitrequest.
- Throughput: at most one write per 2 cycles, since IDLE is always spent between writes.
- Grant is latched: a higher-priority pulse arriving during WRITE does not preempt; it wins at the next IDLE.
- Ordering:
  - Only the pending state is kept, not order. A start and stop pending together for one section issue STOP then GO.
  - Sequential pulses of different types separated by at least 2 cycles per write preserve order.
- Global clear issues its write but does not cancel other pending bits.
- Reset mid-write: avm_write drops immediately (async) and the transaction is abandoned.
- busy = |pending | (state == WRITE).

Test Plan:
- Single start: sec_start = 0001 for 1 cycle, waitrequest = 0 -> one write, address 1, data 0, begintransfer high 1 cycle, 2 cycles after the pulse; busy then falls; drop_count = 0.
- Simultaneous: global_clear, sec_stop = 0010, sec_start = 0100 in the same cycle -> writes in order (addr 0, data 1), (addr 4, data 0), (addr 9, data 0), each separated by one IDLE cycle.
- Waitrequest: start[3] with waitrequest held 3 cycles -> avm_write high 4 cycles, address 13 stable, begintransfer only on the first cycle, pending bit cleared on the 4th.
- Drop: sec_start[0] pulsed 3 times back-to-back while a long waitrequest stalls a prior stop[1] write -> exactly one GO(address 1) issued, drop_count = 2; a pulse on the completion cycle of its own bit is retained, not counted.
- Saturation: 300 drops with DROP_W = 8 -> drop_count = 255.
- Async reset asserted during WRITE with waitrequest = 1 -> avm_write = 0 and busy = 0 immediately; no write issued after release until a new pulse arrives.

Source files
------------

// File: rtl/perf_section_trigger.sv
// Avalon-MM write master that turns section start/stop pulses and a global clear
// request into STOP/GO/reset register writes on the performance counter slave.
module perf_section_trigger #(
   parameter int NUM_SECTIONS = 4,
   parameter int DROP_W       = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_SECTIONS-1:0] sec_start,
   input  logic [NUM_SECTIONS-1:0] sec_stop,
   input  logic                    global_clear,
   output logic [3:0]              avm_address,
   output logic                    avm_write,
   output logic                    avm_begintransfer,
   output logic [31:0]             avm_writedata,
   input  logic                    avm_waitrequest,
   output logic                    busy,
   output logic [DROP_W-1:0]       drop_count
);

   // Event bit layout doubles as the priority order: bit 0 = clear,
   // then stop[0..N-1], then start[0..N-1]; the lowest set bit wins.
   localparam int NUM_EV = 2 * NUM_SECTIONS + 1;
   localparam int CNT_W  = $clog2(NUM_EV + 1);
   localparam int SUM_W  = DROP_W + CNT_W;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t              state_reg;
   logic [NUM_EV-1:0]   pend_reg;
   logic [NUM_EV-1:0]   grant_reg;
   logic [NUM_EV-1:0]   set_vec;
   logic [NUM_EV-1:0]   clr_vec;
   logic [NUM_EV-1:0]   drop_vec;
   logic [NUM_EV-1:0]   pend_next;
   logic [NUM_EV-1:0]   win_vec;
   logic [3:0]          ev_addr [NUM_EV];
   logic [3:0]          win_addr;
   logic [CNT_W-1:0]    drop_inc;
   logic [SUM_W-1:0]    drop_sum;
   logic [DROP_W-1:0]   drop_next;

   assign set_vec    = {sec_start, sec_stop, global_clear};
   assign ev_addr[0] = 4'd0;

   generate
      for (genvar gi = 0; gi < NUM_SECTIONS; gi++) begin : g_addr
         assign ev_addr[1 + gi]                = 4'(4 * gi);
         assign ev_addr[1 + NUM_SECTIONS + gi] = 4'(4 * gi + 1);
      end
   endgenerate

   // Isolate the lowest set pending bit.
   assign win_vec = pend_reg & (~pend_reg + NUM_EV'(1));

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NUM_EV; i++) begin
         if (win_vec[i]) begin
            win_addr = win_addr | ev_addr[i];
         end
      end
   end

   // A new pulse on a bit being cleared this cycle re-arms it rather than dropping.
   assign clr_vec   = (state_reg == WRITE && !avm_waitrequest) ? grant_reg : '0;
   assign drop_vec  = set_vec & pend_reg & ~clr_vec;
   assign pend_next = (pend_reg & ~clr_vec) | set_vec;

   always_comb begin
      drop_inc = '0;
      for (int i = 0; i < NUM_EV; i++) begin
         drop_inc = drop_inc + CNT_W'(drop_vec[i]);
      end
      drop_sum = SUM_W'(drop_count) + SUM_W'(drop_inc);
      if (|drop_sum[SUM_W-1:DROP_W]) begin
         drop_next = '1;
      end else begin
         drop_next = drop_sum[DROP_W-1:0];
      end
   end

   assign busy = (|pend_reg) | (state_reg == WRITE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         pend_reg          <= '0;
         grant_reg         <= '0;
         drop_count        <= '0;
         avm_address       <= '0;
         avm_writedata     <= '0;
         avm_write         <= 1'b0;
         avm_begintransfer <= 1'b0;
      end else begin
         pend_reg   <= pend_next;
         drop_count <= drop_next;
         case (state_reg)
            IDLE: begin
               if (|pend_reg) begin
                  state_reg         <= WRITE;
                  grant_reg         <= win_vec;
                  avm_address       <= win_addr;
                  avm_writedata     <= {31'd0, win_vec[0]};
                  avm_write         <= 1'b1;
                  avm_begintransfer <= 1'b1;
               end
            end
            WRITE: begin
               avm_begintransfer <= 1'b0;
               if (!avm_waitrequest) begin
                  state_reg <= IDLE;
                  grant_reg <= '0;
                  avm_write <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
